escal_alu: RTL and testbench

32-bit scalar ALU for the processor's scalar execute stage. It performs one of eight arithmetic, logic or shift operations selected by a 3-bit opcode, and produces the result plus status flags and compare outputs. The outputs are registered, so consumers see them one clock after the operands are presented.

---
 rtl/escal_alu_pkg.sv | 17 +
 rtl/escal_alu_core.sv | 92 +++++++++
 rtl/escal_alu.sv | 70 +++++++
 tb/tb_escal_alu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/escal_alu_pkg.sv
// Shared opcode encoding and width for the scalar ALU.
package escal_alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_OR  = 3'd4,
        OP_AND = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } alu_op_t;

endpackage

// File: rtl/escal_alu_core.sv
// Purely combinational ALU datapath: result, carry/overflow flags and the
// opcode-independent compare outputs.
module escal_alu_core
    import escal_alu_pkg::*;
(
    input  logic [2:0]        alu_op,
    input  logic              cin,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              carry,
    output logic              overflow,
    output logic              zero,
    output logic              negative,
    output logic              eq,
    output logic              blt
);

    alu_op_t               op;
    logic [DATA_W-1:0]     b_eff;
    logic                  cin_eff;
    logic [DATA_W:0]       sum_ext;
    logic [2*DATA_W-1:0]   prod;
    logic [4:0]            sh;
    logic [DATA_W:0]       sll_ext;
    logic [DATA_W:0]       srl_ext;
    logic                  add_ovf;

    assign op = alu_op_t'(alu_op);

    // Shared adder: SUB reuses it as A + ~B + 1, so Cout=1 means "no borrow".
    assign b_eff   = (op == OP_SUB) ? ~op_b : op_b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;
    assign sum_ext = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_eff};
    // Overflow: adder inputs share a sign but the sum sign differs.
    assign add_ovf = (op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                     (sum_ext[DATA_W-1] != op_a[DATA_W-1]);

    assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

    // Shifts use one extra bit so the last bit shifted out lands in the
    // extension bit; a shift of zero leaves that bit clear.
    assign sh      = op_b[4:0];
    assign sll_ext = {1'b0, op_a} << sh;
    assign srl_ext = {op_a, 1'b0} >> sh;

    // Opcode-dependent result and flag selection.
    always_comb begin
        result   = '0;
        cout     = 1'b0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result   = sum_ext[DATA_W-1:0];
                cout     = sum_ext[DATA_W];
                carry    = sum_ext[DATA_W];
                overflow = add_ovf;
            end
            OP_MUL: begin
                result   = prod[DATA_W-1:0];
                overflow = |prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                if (op_b == '0) begin
                    result   = '1;
                    overflow = 1'b1;
                end else begin
                    result = op_a / op_b;
                end
            end
            OP_OR:  result = op_a | op_b;
            OP_AND: result = op_a & op_b;
            OP_SLL: begin
                result = sll_ext[DATA_W-1:0];
                carry  = sll_ext[DATA_W];
            end
            OP_SRL: begin
                result = srl_ext[DATA_W:1];
                carry  = srl_ext[0];
            end
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[DATA_W-1];
    assign eq       = (op_a == op_b);
    assign blt      = ($signed(op_a) < $signed(op_b));

endmodule

// File: rtl/escal_alu.sv
// Scalar ALU top: combinational core followed by one output register stage
// with asynchronous clear.
module escal_alu
    import escal_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Cin,
    input  logic [2:0]        ALUop,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    output logic              Cout,
    output logic [DATA_W-1:0] Result,
    output logic              Zero,
    output logic              Carry,
    output logic              OverFlow,
    output logic              Negative,
    output logic              eq,
    output logic              blt
);

    logic [DATA_W-1:0] result_next;
    logic              cout_next;
    logic              carry_next;
    logic              overflow_next;
    logic              zero_next;
    logic              negative_next;
    logic              eq_next;
    logic              blt_next;

    escal_alu_core u_core (
        .alu_op   (ALUop),
        .cin      (Cin),
        .op_a     (OpA),
        .op_b     (OpB),
        .result   (result_next),
        .cout     (cout_next),
        .carry    (carry_next),
        .overflow (overflow_next),
        .zero     (zero_next),
        .negative (negative_next),
        .eq       (eq_next),
        .blt      (blt_next)
    );

    // Output stage: everything clears on reset (Zero included), then
    // captures the core outputs each rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result   <= '0;
            Cout     <= 1'b0;
            Carry    <= 1'b0;
            OverFlow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            eq       <= 1'b0;
            blt      <= 1'b0;
        end else begin
            Result   <= result_next;
            Cout     <= cout_next;
            Carry    <= carry_next;
            OverFlow <= overflow_next;
            Zero     <= zero_next;
            Negative <= negative_next;
            eq       <= eq_next;
            blt      <= blt_next;
        end
    end

endmodule

// File: tb/tb_escal_alu.sv
// Self-checking bench for escal_alu: directed ops, reset behaviour and a
// back-to-back run, with a scoreboard queue of expected output vectors.
module tb_escal_alu;

    logic        clk;
    logic        rst;
    logic        Cin;
    logic [2:0]  ALUop;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        Cout;
    logic [31:0] Result;
    logic        Zero;
    logic        Carry;
    logic        OverFlow;
    logic        Negative;
    logic        eq;
    logic        blt;

    int checks = 0;
    int errors = 0;

    // Packed expectation: {Cout, Result, Zero, Carry, OverFlow, Negative, eq, blt}
    logic [38:0] sb_q[$];

    escal_alu dut (
        .clk      (clk),
        .rst      (rst),
        .Cin      (Cin),
        .ALUop    (ALUop),
        .OpA      (OpA),
        .OpB      (OpB),
        .Cout     (Cout),
        .Result   (Result),
        .Zero     (Zero),
        .Carry    (Carry),
        .OverFlow (OverFlow),
        .Negative (Negative),
        .eq       (eq),
        .blt      (blt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] observed();
        return {Cout, Result, Zero, Carry, OverFlow, Negative, eq, blt};
    endfunction

    // Reference model written from the operation definitions.
    function automatic logic [38:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        logic [63:0] wide;
        logic [31:0] r;
        logic        co;
        logic        ca;
        logic        ov;
        int          sh;
        r  = 32'd0;
        co = 1'b0;
        ca = 1'b0;
        ov = 1'b0;
        sh = int'(b[4:0]);
        case (op)
            3'd0: begin
                wide = {32'd0, a} + {32'd0, b} + {63'd0, cin};
                r = wide[31:0]; co = wide[32]; ca = co;
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                wide = {32'd0, a} + {32'd0, ~b} + 64'd1;
                r = wide[31:0]; co = wide[32]; ca = co;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: begin
                wide = {32'd0, a} * {32'd0, b};
                r = wide[31:0];
                ov = (wide[63:32] != 32'd0);
            end
            3'd3: begin
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF; ov = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            3'd4: r = a | b;
            3'd5: r = a & b;
            3'd6: begin
                r  = a << sh;
                ca = (sh == 0) ? 1'b0 : a[32 - sh];
            end
            default: begin
                r  = a >> sh;
                ca = (sh == 0) ? 1'b0 : a[sh - 1];
            end
        endcase
        return {co, r, (r == 32'd0), ca, ov, r[31], (a == b), ($signed(a) < $signed(b))};
    endfunction

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-10s obs=%h exp=%h", tag, obs, exp);
    endtask

    // Drive one op at the falling edge, then compare one step after the next
    // rising edge against the head of the scoreboard.
    task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin);
        @(negedge clk);
        ALUop = op; OpA = a; OpB = b; Cin = cin;
        sb_q.push_back(model(op, a, b, cin));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_empty"}, observed(), ~observed());
        end else begin
            check(tag, observed(), sb_q.pop_front());
        end
    endtask

    logic [38:0] sll1_vec;

    initial begin
        rst = 1'b1; Cin = 1'b0; ALUop = 3'd0; OpA = 32'd0; OpB = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_init", observed(), 39'd0);
        rst = 1'b0;

        // Spec-valued spot checks alongside the model.
        step("add_6_2",   3'd0, 32'd6, 32'd2, 1'b0);
        check("add_6_2k", {Cout, Result, Zero}, {1'b0, 32'd8, 1'b0});
        step("add_2_7",   3'd0, 32'd2, 32'd7, 1'b0);
        check("add_2_7k", {7'd0, Result}, {7'd0, 32'd9});
        step("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("add_wrapk", {Result, Zero, Carry, Cout}, {32'd0, 1'b1, 1'b1, 1'b1});
        step("add_ovf",   3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check("add_ovfk", {OverFlow, Negative}, {1'b1, 1'b1});
        step("add_cin",   3'd0, 32'd5, 32'd5, 1'b1);
        step("sub_10_5",  3'd1, 32'd10, 32'd5, 1'b0);
        check("sub_10_5k", {Result, Carry, blt}, {32'd5, 1'b1, 1'b0});
        step("sub_5_10",  3'd1, 32'd5, 32'd10, 1'b1);
        check("sub_5_10k", {Result, Negative, Carry, blt, eq},
              {32'hFFFF_FFFB, 1'b1, 1'b0, 1'b1, 1'b0});
        step("sub_eq",    3'd1, 32'd77, 32'd77, 1'b0);
        step("sub_sovf",  3'd1, 32'h8000_0000, 32'd1, 1'b0);
        step("mul",       3'd2, 32'd10, 32'd30, 1'b0);
        check("mulk", {7'd0, Result}, {7'd0, 32'd300});
        step("div",       3'd3, 32'd300, 32'd30, 1'b0);
        check("divk", {7'd0, Result}, {7'd0, 32'd10});
        step("mul_ovf",   3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0);
        check("mul_ovfk", {Result, OverFlow}, {32'd0, 1'b1});
        step("div0",      3'd3, 32'd7, 32'd0, 1'b0);
        check("div0k", {Result, OverFlow}, {32'hFFFF_FFFF, 1'b1});
        step("or",        3'd4, 32'd10, 32'd1, 1'b1);
        step("and",       3'd5, 32'd10, 32'd6, 1'b1);
        step("sll_2",     3'd6, 32'd10, 32'd2, 1'b0);
        check("sll_2k", {Result, Carry}, {32'd40, 1'b0});
        step("sll_cout",  3'd6, 32'h8000_0000, 32'd1, 1'b0);
        step("srl_1",     3'd7, 32'd10, 32'd1, 1'b0);
        check("srl_1k", {Result, Carry}, {32'd5, 1'b0});
        step("srl_c",     3'd7, 32'h8000_0001, 32'd1, 1'b0);
        check("srl_ck", {Result, Carry}, {32'h4000_0000, 1'b1});
        step("sll_0",     3'd6, 32'hF000_000F, 32'd0, 1'b0);
        step("sll_1",     3'd6, 32'hC000_0003, 32'd1, 1'b0);
        sll1_vec = observed();
        step("sll_33",    3'd6, 32'hC000_0003, 32'd33, 1'b0);
        check("sll_33v1", {observed()} & ~39'h3, sll1_vec & ~39'h3);
        step("srl_33",    3'd7, 32'h8000_0001, 32'd33, 1'b0);
        step("srl_31",    3'd7, 32'h8000_0001, 32'd31, 1'b0);

        // Mid-stream reset: outputs clear without a clock edge, the
        // in-flight op is discarded and nothing latches while rst is held.
        step("pre_rst",   3'd0, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        ALUop = 3'd4; OpA = 32'h1234_5678; OpB = 32'd1;
        #2 rst = 1'b1;
        #1 check("rst_async", observed(), 39'd0);
        @(posedge clk);
        #1 check("rst_hold", observed(), 39'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back run: each result one edge after its operands, in order.
        for (int i = 0; i < 10; i++) begin
            step("b2b", 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 40), 1'($urandom));
        end

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
